brent_kung_pipe_adder: RTL

//  Parametrised, pipelined Brent-Kung prefix adder/subtractor; successor to the fixed 16-bit combinational BK tree.

---
 rtl/brent_kung_pipe_adder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/brent_kung_pipe_adder.sv
// Pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control.
// Stage 0 holds propagate/generate, stage 1 the up-sweep, stage 2 the sum and flags.
module brent_kung_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : gBadWidth
        $error("brent_kung_pipe_adder: WIDTH must be a power of two in 4..64");
    end

    logic v0_q, v1_q, v2_q;
    logic adv0, adv1, adv2;

    // A stage may take new data when it is empty or its contents move on this cycle.
    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign adv0     = !v0_q || adv1;
    assign in_ready = adv0;

    logic [WIDTH-1:0] bEff;
    logic [WIDTH-1:0] p0_d, g0_d, p0_q, g0_q;
    logic             c0_d, c0_q;

    assign bEff = sub ? ~data2 : data2;
    assign p0_d = data1 ^ bEff;
    assign g0_d = data1 & bEff;
    assign c0_d = sub | cin;

    logic [WIDTH-1:0] upP_d, upG_d, upP_q, upG_q, p1_q;
    logic             c1_q;

    // Carry-in is folded into bit 0 so every prefix G becomes the carry out of its bit.
    always_comb begin
        upP_d    = p0_q;
        upG_d    = g0_q;
        upG_d[0] = g0_q[0] | (p0_q[0] & c0_q);
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    upG_d[i] = upG_d[i] | (upP_d[i] & upG_d[i - (1 << l)]);
                    upP_d[i] = upP_d[i] & upP_d[i - (1 << l)];
                end
            end
        end
    end

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d, zero_d;

    // Grey cells fill the bits midway between the up-sweep's full prefixes.
    always_comb begin
        carry = upG_q;
        for (int l = LEVELS - 2; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    carry[i] = carry[i] | (upP_q[i] & carry[i - (1 << l)]);
                end
            end
        end
        sum_d  = p1_q ^ {carry[WIDTH-2:0], c1_q};
        cout_d = carry[WIDTH-1];
        ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];
        zero_d = (sum_d == '0);
    end

    logic [WIDTH-1:0] res_q;
    logic             cout_q, ovf_q, zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            p0_q   <= '0;
            g0_q   <= '0;
            c0_q   <= 1'b0;
            upP_q  <= '0;
            upG_q  <= '0;
            p1_q   <= '0;
            c1_q   <= 1'b0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (adv0) begin
                v0_q <= in_valid;
                if (in_valid) begin
                    p0_q <= p0_d;
                    g0_q <= g0_d;
                    c0_q <= c0_d;
                end
            end
            if (adv1) begin
                v1_q <= v0_q;
                if (v0_q) begin
                    upP_q <= upP_d;
                    upG_q <= upG_d;
                    p1_q  <= p0_q;
                    c1_q  <= c0_q;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    res_q  <= sum_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign out_valid = v2_q;
    assign res       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
